// File: rtl/indirect_protect_ctrl.sv
// ---------------------------------------------------------------------------
// indirect_protect_ctrl
//
// Controller and configurator for the indirect-pointer store detector.
// Owns the detector's write-block window, arms/disarms the detector through
// its sync_reset, captures the PC of each detection, keeps a saturating
// event count, raises a trap request to the exception unit, waits out the
// handler and then holds the detector in reset for a cooldown period before
// re-arming it.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   cfg_wr/cfg_addr/cfg_wdata  config write (0=CTRL 1=BLK_START 2=BLK_END 3=STATUS)
//   cfg_rdata                  combinational read of the register at cfg_addr
//   det_active_in, pc_in       detection pulse and the PC presented with it
//   exception_handler_active   trap handler is running
//   trap_ack                   exception unit accepts the trap request
//   det_sync_reset             holds the detector in reset
//   det_blk_wr_start/end       write-block window to the detector
//   trap_req, trap_pc          trap request and PC of the last detection
//   event_count                saturating detection count
//   armed                      controller is not DISARMED
//
// CTRL write: bit0 arm, bit1 trap_en, bit2 clear_count (self-clearing).
// CTRL read : {trap_en, armed}.
// STATUS    : [CNT_BITS-1:0] event_count, [18:16] state code
//             (0 DISARMED, 1 ARMED, 2 TRAP_REQ, 3 WAIT_HANDLER, 4 COOLDOWN),
//             [20] err (last arm attempt had an empty window), [21] trap_en.
// ---------------------------------------------------------------------------
module indirect_protect_ctrl #(
    parameter int MEM_ADDR_BITS   = 16,
    parameter int PC_BITWIDTH     = 32,
    parameter int CNT_BITS        = 8,
    parameter int COOLDOWN_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_wr,
    input  logic [1:0]               cfg_addr,
    input  logic [31:0]              cfg_wdata,
    output logic [31:0]              cfg_rdata,
    input  logic                     det_active_in,
    input  logic [PC_BITWIDTH-1:0]   pc_in,
    input  logic                     exception_handler_active,
    input  logic                     trap_ack,
    output logic                     det_sync_reset,
    output logic [MEM_ADDR_BITS-1:0] det_blk_wr_start,
    output logic [MEM_ADDR_BITS-1:0] det_blk_wr_end,
    output logic                     trap_req,
    output logic [PC_BITWIDTH-1:0]   trap_pc,
    output logic [CNT_BITS-1:0]      event_count,
    output logic                     armed
);

    typedef enum logic [4:0] {
        DISARMED     = 5'b00001,
        ARMED        = 5'b00010,
        TRAP_REQ     = 5'b00100,
        WAIT_HANDLER = 5'b01000,
        COOLDOWN     = 5'b10000
    } state_t;

    localparam int CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam logic [CD_W-1:0]     CD_LOAD = CD_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    state_t                   state;
    state_t                   state_next;
    logic                     trap_en;
    logic                     err;
    logic                     seen;
    logic [CD_W-1:0]          cool_cnt;
    logic [2:0]               state_code;

    logic ctrl_wr;
    logic arm_req;
    logic disarm_req;
    logic clear_req;
    logic window_ok;
    logic det_take;
    logic arm_attempt;

    // Bits of the write bus above the window width carry no meaning.
    logic unused_wdata;
    assign unused_wdata = ^cfg_wdata[31:MEM_ADDR_BITS];

    assign ctrl_wr     = cfg_wr && (cfg_addr == 2'd0);
    assign arm_req     = ctrl_wr && cfg_wdata[0];
    assign disarm_req  = ctrl_wr && !cfg_wdata[0];
    assign clear_req   = ctrl_wr && cfg_wdata[2];
    assign window_ok   = det_blk_wr_start < det_blk_wr_end;
    assign arm_attempt = (state == DISARMED) && arm_req;
    // A disarm in the same cycle suppresses the detection entirely.
    assign det_take    = (state == ARMED) && det_active_in && !disarm_req;

    // Moore outputs decoded from the state register, so the asynchronous
    // reset drives them to their idle values immediately.
    assign armed          = (state != DISARMED);
    assign det_sync_reset = (state != ARMED);
    assign trap_req       = (state == TRAP_REQ);

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            DISARMED:     if (arm_req && window_ok) state_next = ARMED;
            ARMED:        if (det_active_in) state_next = trap_en ? TRAP_REQ : COOLDOWN;
            TRAP_REQ:     if (trap_ack) state_next = WAIT_HANDLER;
            WAIT_HANDLER: if (seen && !exception_handler_active) state_next = COOLDOWN;
            COOLDOWN:     if (cool_cnt == '0) state_next = ARMED;
            default:      state_next = DISARMED;
        endcase
        if (disarm_req) state_next = DISARMED;
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= DISARMED;
        else       state <= state_next;
    end

    // Configuration registers; the window is locked unless disarmed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            det_blk_wr_start <= '0;
            det_blk_wr_end   <= '0;
            trap_en          <= 1'b0;
            err              <= 1'b0;
        end else begin
            if (cfg_wr && (cfg_addr == 2'd1) && (state == DISARMED))
                det_blk_wr_start <= cfg_wdata[MEM_ADDR_BITS-1:0];
            if (cfg_wr && (cfg_addr == 2'd2) && (state == DISARMED))
                det_blk_wr_end <= cfg_wdata[MEM_ADDR_BITS-1:0];
            if (ctrl_wr)
                trap_en <= cfg_wdata[1];
            if (arm_attempt)
                err <= !window_ok;
        end
    end

    // Detection capture and saturating count; clear beats increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trap_pc     <= '0;
            event_count <= '0;
        end else begin
            if (det_take)
                trap_pc <= pc_in;
            if (clear_req)
                event_count <= '0;
            else if (det_take && (event_count != CNT_MAX))
                event_count <= event_count + 1'b1;
        end
    end

    // Handler-seen flag lives only inside WAIT_HANDLER; the cooldown counter
    // is preloaded outside COOLDOWN so it starts full on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen     <= 1'b0;
            cool_cnt <= CD_LOAD;
        end else begin
            seen <= (state == WAIT_HANDLER) ? (seen | exception_handler_active) : 1'b0;
            if (state != COOLDOWN)
                cool_cnt <= CD_LOAD;
            else if (cool_cnt != '0)
                cool_cnt <= cool_cnt - 1'b1;
        end
    end

    always_comb begin
        state_code = 3'd0;
        unique case (state)
            DISARMED:     state_code = 3'd0;
            ARMED:        state_code = 3'd1;
            TRAP_REQ:     state_code = 3'd2;
            WAIT_HANDLER: state_code = 3'd3;
            COOLDOWN:     state_code = 3'd4;
            default:      state_code = 3'd0;
        endcase
    end

    always_comb begin
        cfg_rdata = '0;
        unique case (cfg_addr)
            2'd0: cfg_rdata[1:0] = {trap_en, armed};
            2'd1: cfg_rdata[MEM_ADDR_BITS-1:0] = det_blk_wr_start;
            2'd2: cfg_rdata[MEM_ADDR_BITS-1:0] = det_blk_wr_end;
            2'd3: begin
                cfg_rdata[CNT_BITS-1:0] = event_count;
                cfg_rdata[18:16]        = state_code;
                cfg_rdata[20]           = err;
                cfg_rdata[21]           = trap_en;
            end
            default: cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_indirect_protect_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for indirect_protect_ctrl: directed scenarios followed by a
// randomized phase, all checked every cycle against a behavioural model.
// ---------------------------------------------------------------------------
module tb_indirect_protect_ctrl;

    localparam int CD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_wr;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        det_active_in;
    logic [31:0] pc_in;
    logic        exception_handler_active;
    logic        trap_ack;
    logic        det_sync_reset;
    logic [15:0] det_blk_wr_start;
    logic [15:0] det_blk_wr_end;
    logic        trap_req;
    logic [31:0] trap_pc;
    logic [7:0]  event_count;
    logic        armed;

    indirect_protect_ctrl #(
        .MEM_ADDR_BITS(16), .PC_BITWIDTH(32), .CNT_BITS(8), .COOLDOWN_CYCLES(CD)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .det_active_in(det_active_in), .pc_in(pc_in),
        .exception_handler_active(exception_handler_active), .trap_ack(trap_ack),
        .det_sync_reset(det_sync_reset),
        .det_blk_wr_start(det_blk_wr_start), .det_blk_wr_end(det_blk_wr_end),
        .trap_req(trap_req), .trap_pc(trap_pc), .event_count(event_count), .armed(armed)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit req_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 disarmed, 1 armed, 2 trap request, 3 waiting on handler, 4 cooldown
    int          m_mode;
    int          m_cd;      // cooldown cycles still to serve
    bit          m_seen;
    bit          m_ten, m_err;
    logic [15:0] m_start, m_end;
    logic [31:0] m_pc;
    int          m_cnt;

    task automatic model_reset();
        m_mode = 0; m_cd = 0; m_seen = 0; m_ten = 0; m_err = 0;
        m_start = '0; m_end = '0; m_pc = '0; m_cnt = 0;
    endtask

    task automatic model_step(input logic wr, input logic [1:0] addr, input logic [31:0] wd,
                              input logic det, input logic [31:0] pc,
                              input logic h, input logic ack);
        bit ctrl, disarm;
        int nm;
        ctrl   = wr && addr == 2'd0;
        disarm = ctrl && !wd[0];
        nm     = m_mode;
        if (wr && addr == 2'd1 && m_mode == 0) m_start = wd[15:0];
        if (wr && addr == 2'd2 && m_mode == 0) m_end   = wd[15:0];
        case (m_mode)
            0: if (ctrl && wd[0]) begin
                   // window is compared before this cycle's register writes
                   if (m_start_prev < m_end_prev) begin nm = 1; m_err = 0; end
                   else m_err = 1;
               end
            1: if (det && !disarm) begin
                   m_pc  = pc;
                   m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                   if (m_ten) nm = 2;
                   else begin nm = 4; m_cd = CD; end
               end
            2: if (ack) begin nm = 3; m_seen = 0; end
            3: if (m_seen && !h) begin nm = 4; m_cd = CD; end
               else if (h) m_seen = 1;
            4: begin
                   m_cd--;
                   if (m_cd == 0) nm = 1;
               end
            default: nm = 0;
        endcase
        if (ctrl) m_ten = wd[1];
        if (ctrl && wd[2]) m_cnt = 0;
        if (disarm) nm = 0;
        m_mode = nm;
    endtask

    // Window values before the step (CTRL and window writes never share a
    // cycle, but keep the comparison on pre-edge values explicitly).
    logic [15:0] m_start_prev, m_end_prev;

    function automatic logic [31:0] exp_rdata(input logic [1:0] addr);
        logic [31:0] r;
        r = '0;
        case (addr)
            2'd0: r = {30'd0, m_ten, (m_mode != 0)};
            2'd1: r = {16'd0, m_start};
            2'd2: r = {16'd0, m_end};
            default: begin
                r[7:0]   = 8'(m_cnt);
                r[18:16] = 3'(m_mode);
                r[20]    = m_err;
                r[21]    = m_ten;
            end
        endcase
        return r;
    endfunction

    task automatic check_outputs();
        check("armed",          {31'd0, armed},          {31'd0, m_mode != 0});
        check("det_sync_reset", {31'd0, det_sync_reset}, {31'd0, m_mode != 1});
        check("trap_req",       {31'd0, trap_req},       {31'd0, m_mode == 2});
        check("trap_pc",        trap_pc,                 m_pc);
        check("event_count",    {24'd0, event_count},    m_cnt);
        check("blk_start",      {16'd0, det_blk_wr_start}, {16'd0, m_start});
        check("blk_end",        {16'd0, det_blk_wr_end},   {16'd0, m_end});
    endtask

    // One clock cycle: entered just after a falling edge.
    task automatic cycle(input logic wr, input logic [1:0] addr, input logic [31:0] wd,
                         input logic det, input logic [31:0] pc,
                         input logic h, input logic ack);
        cfg_wr = wr; cfg_addr = addr; cfg_wdata = wd;
        det_active_in = det; pc_in = pc;
        exception_handler_active = h; trap_ack = ack;
        #1;
        check("cfg_rdata", cfg_rdata, exp_rdata(addr));
        @(posedge clk);
        m_start_prev = m_start; m_end_prev = m_end;
        model_step(wr, addr, wd, det, pc, h, ack);
        @(negedge clk);
        check_outputs();
        if (trap_req) req_seen = 1;
    endtask

    task automatic idle(input int n, input logic h = 1'b0);
        for (int i = 0; i < n; i++) cycle(0, 2'd3, 32'd0, 0, 32'd0, h, 0);
    endtask

    task automatic wr_reg(input logic [1:0] addr, input logic [31:0] data);
        cycle(1, addr, data, 0, 32'd0, 0, 0);
    endtask

    task automatic peek(input logic [1:0] addr);
        cfg_wr = 0; det_active_in = 0; trap_ack = 0; cfg_addr = addr;
        #1;
    endtask

    initial begin
        int k;
        logic [31:0] wd;
        logic        hh;
        reset = 1;
        cfg_wr = 0; cfg_addr = 0; cfg_wdata = 0; det_active_in = 0; pc_in = 0;
        exception_handler_active = 0; trap_ack = 0;
        model_reset();
        m_start_prev = '0; m_end_prev = '0;
        repeat (3) @(negedge clk);

        // 1: reset values, then program window and arm
        check("rst_armed", {31'd0, armed}, 32'd0);
        check("rst_sync",  {31'd0, det_sync_reset}, 32'd1);
        check("rst_req",   {31'd0, trap_req}, 32'd0);
        check("rst_pc",    trap_pc, 32'd0);
        check("rst_cnt",   {24'd0, event_count}, 32'd0);
        peek(2'd3); check("rst_status", cfg_rdata, 32'd0);
        reset = 0;
        @(negedge clk);
        wr_reg(2'd1, 32'h0100);
        wr_reg(2'd2, 32'h0200);
        wr_reg(2'd0, 32'h3);
        check("t1_armed", {31'd0, armed}, 32'd1);
        check("t1_sync",  {31'd0, det_sync_reset}, 32'd0);
        check("t1_start", {16'd0, det_blk_wr_start}, 32'h0100);
        check("t1_end",   {16'd0, det_blk_wr_end}, 32'h0200);

        // 2: detection with trap, ack after 3 cycles, handler 5 cycles
        cycle(0, 2'd3, 0, 1, 32'h80043298, 0, 0);
        check("t2_req", {31'd0, trap_req}, 32'd1);
        check("t2_pc",  trap_pc, 32'h80043298);
        check("t2_cnt", {24'd0, event_count}, 32'd1);
        idle(2);
        cycle(0, 2'd3, 0, 0, 0, 0, 1);
        check("t2_req_drop", {31'd0, trap_req}, 32'd0);
        idle(5, 1'b1);
        idle(1);
        k = 0;
        while (det_sync_reset && k < 20) begin k++; idle(1); end
        check("t2_cooldown_len", k, CD);
        check("t2_rearmed", {31'd0, armed & ~det_sync_reset}, 32'd1);

        // 3: illegal window, then window lock while armed
        wr_reg(2'd0, 32'h0);
        wr_reg(2'd1, 32'h0200);
        wr_reg(2'd0, 32'h1);
        check("t3_not_armed", {31'd0, armed}, 32'd0);
        peek(2'd3); check("t3_err", {31'd0, cfg_rdata[20]}, 32'd1);
        wr_reg(2'd1, 32'h0100);
        wr_reg(2'd0, 32'h1);
        peek(2'd3); check("t3_err_clr", {31'd0, cfg_rdata[20]}, 32'd0);
        wr_reg(2'd1, 32'h0300);
        check("t3_locked", {16'd0, det_blk_wr_start}, 32'h0100);

        // 4: saturation without traps; pulses during cooldown are ignored
        wr_reg(2'd0, 32'h5);
        req_seen = 0;
        for (int i = 0; i < 300; i++) begin
            cycle(0, 2'd3, 0, 1, $urandom, 0, 0);
            for (int j = 0; j < CD; j++)
                cycle(0, 2'd3, 0, 1'($urandom_range(0, 1)), $urandom, 0, 0);
        end
        check("t4_sat", {24'd0, event_count}, 32'd255);
        check("t4_no_req", {31'd0, req_seen}, 32'd0);

        // 5: disarm beats detection; clear beats increment
        cycle(1, 2'd0, 32'h0, 1, 32'hdead0000, 0, 0);
        check("t5_disarmed", {31'd0, armed}, 32'd0);
        check("t5_cnt_kept", {24'd0, event_count}, 32'd255);
        wr_reg(2'd0, 32'h1);
        cycle(1, 2'd0, 32'h5, 1, 32'h12345678, 0, 0);
        check("t5_cleared", {24'd0, event_count}, 32'd0);
        idle(CD);

        // 6: asynchronous reset while a trap is requested
        wr_reg(2'd0, 32'h3);
        cycle(0, 2'd3, 0, 1, 32'h00c0ffee, 0, 0);
        check("t6_req", {31'd0, trap_req}, 32'd1);
        #2 reset = 1;
        #1;
        check("t6_req_rst",   {31'd0, trap_req}, 32'd0);
        check("t6_sync_rst",  {31'd0, det_sync_reset}, 32'd1);
        check("t6_armed_rst", {31'd0, armed}, 32'd0);
        cfg_addr = 2'd1; #1; check("t6_start_rst", cfg_rdata, 32'd0);
        cfg_addr = 2'd2; #1; check("t6_end_rst", cfg_rdata, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 0;
        idle(2);

        // randomized phase
        hh = 0;
        for (int i = 0; i < 3000; i++) begin
            wd = $urandom;
            if ($urandom_range(0, 7) != 0) wd[0] = 1'b1;
            if ($urandom_range(0, 7) != 0) wd[2] = 1'b0;
            if ($urandom_range(0, 3) == 0) hh = ~hh;
            cycle(($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)), wd,
                  ($urandom_range(0, 2) == 0), $urandom, hh,
                  ($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
